// File: rtl/reg_write_arbiter_amisha_pkg.sv
// Shared types and the round-robin pick helper for reg_write_arbiter_amisha.
// Optional per-requester pointer lock is enabled with REG_ARB_LOCK_EN.
package reg_arb_amisha_pkg;

  localparam int unsigned MAX_NREQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // First set request at or above ptr, wrapping nreq-1 -> 0; caller guarantees req != 0.
  function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned nreq);
    int unsigned winner;
    logic        found;
    winner = 0;
    found  = 1'b0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      int unsigned idx;
      idx = ptr + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && !found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_amisha_if.sv
// Requester-side bus of the shared holding register; master = requesters, slave = arbiter.
// lock_amisha exists only when REG_ARB_LOCK_EN is defined.
interface reg_write_arbiter_amisha_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_amisha;
  logic [NREQ*WIDTH-1:0] d_amisha;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0]       lock_amisha;
`endif
  logic [NREQ-1:0]       gnt_amisha;
  logic [WIDTH-1:0]      q_amisha;
  logic [IDW-1:0]        wr_id_amisha;
  logic                  busy_amisha;

  modport master (
    output req_amisha, d_amisha,
`ifdef REG_ARB_LOCK_EN
    output lock_amisha,
`endif
    input  gnt_amisha, q_amisha, wr_id_amisha, busy_amisha
  );

  modport slave (
    input  req_amisha, d_amisha,
`ifdef REG_ARB_LOCK_EN
    input  lock_amisha,
`endif
    output gnt_amisha, q_amisha, wr_id_amisha, busy_amisha
  );
endinterface

// File: rtl/reg_write_arbiter_amisha_sync.sv
// WIDTH-bit holding register with synchronous active-high reset and load enable.
module reg_sync_amisha #(
  parameter int WIDTH = 8
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha)  q <= '0;
    else if (en)       q <= d;
  end
endmodule

// File: rtl/reg_write_arbiter_amisha.sv
// Round-robin write arbiter in front of one shared holding register (IDLE/ACK FSM).
// Define REG_ARB_LOCK_EN to let a locked winner keep top priority.
module reg_write_arbiter_amisha
  import reg_arb_amisha_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input logic                        clk_amisha,
  input logic                        reset_amisha,
  reg_write_arbiter_amisha_if.slave  bus
);
  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [MAX_NREQ-1:0]  req_ext;
  int unsigned          pick;
  logic [IDW-1:0]       win;
  logic                 any_req;
  logic                 capture;
  logic [IDW-1:0]       ptr_next;
  logic [WIDTH-1:0]     win_data;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = bus.req_amisha;
  end

  assign any_req  = |bus.req_amisha;
  assign pick     = rr_pick(req_ext, 32'(ptr), NREQ);
  assign win      = IDW'(pick);
  assign capture  = (state == ST_IDLE) && any_req;
  assign win_data = bus.d_amisha[win*WIDTH +: WIDTH];

  always_comb begin
    ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef REG_ARB_LOCK_EN
    if (bus.lock_amisha[win]) ptr_next = win;
`endif
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      bus.gnt_amisha   <= '0;
      bus.wr_id_amisha <= '0;
      bus.busy_amisha  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            bus.gnt_amisha   <= NREQ'(1) << win;
            bus.wr_id_amisha <= win;
            bus.busy_amisha  <= 1'b1;
            ptr              <= ptr_next;
            state            <= ST_ACK;
          end else begin
            bus.gnt_amisha  <= '0;
            bus.busy_amisha <= 1'b0;
          end
        end
        default: begin
          bus.gnt_amisha  <= '0;
          bus.busy_amisha <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

  reg_sync_amisha #(.WIDTH(WIDTH)) u_q (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .en           (capture),
    .d            (win_data),
    .q            (bus.q_amisha)
  );
endmodule

// File: tb/tb_reg_write_arbiter_amisha.sv
// Self-checking bench for reg_write_arbiter_amisha: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_reg_write_arbiter_amisha;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk_amisha = 1'b0;
  logic reset_amisha;
  always #5 clk_amisha = ~clk_amisha;

  reg_write_arbiter_amisha_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  reg_write_arbiter_amisha #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .bus          (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model of the spec rules
  bit        m_ack;
  int        m_ptr;
  logic [7:0] m_q;
  int        m_wr_id;
  logic [3:0] m_gnt;
  bit        m_busy;
  int        grants[$];
  logic [7:0] gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_lock();
`ifdef REG_ARB_LOCK_EN
    return bus.lock_amisha;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic model_edge();
    logic [3:0] req;
    int w;
    bit found;
    req = bus.req_amisha;
    if (reset_amisha) begin
      m_ack = 0; m_ptr = 0; m_q = 8'h00; m_wr_id = 0; m_gnt = 4'b0; m_busy = 0;
    end else if (m_ack) begin
      m_ack = 0; m_gnt = 4'b0; m_busy = 0;
    end else if (req != 4'b0) begin
      found = 0; w = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!found && req[i]) begin w = i; found = 1; end
      end
      m_q     = bus.d_amisha[w*WIDTH +: WIDTH];
      m_wr_id = w;
      m_gnt   = 4'(1 << w);
      m_busy  = 1;
      m_ack   = 1;
      m_ptr   = cur_lock()[w] ? w : (w + 1) % NREQ;
    end else begin
      m_gnt = 4'b0; m_busy = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_amisha);
    #1;
    check("q",     32'(bus.q_amisha),     32'(m_q));
    check("gnt",   32'(bus.gnt_amisha),   32'(m_gnt));
    check("wr_id", 32'(bus.wr_id_amisha), 32'(m_wr_id));
    check("busy",  32'(bus.busy_amisha),  32'(m_busy));
    if (bus.gnt_amisha != '0) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.gnt_amisha[i]) grants.push_back(i);
      gq.push_back(bus.q_amisha);
    end
  endtask

  task automatic do_reset();
    reset_amisha = 1'b1;
    bus.req_amisha = '0;
    tick();
    reset_amisha = 1'b0;
    grants.delete();
    gq.delete();
  endtask

  task automatic set_d(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    bus.d_amisha = {d3, d2, d1, d0};
  endtask

  initial begin
    reset_amisha   = 1'b1;
    bus.req_amisha = '0;
    bus.d_amisha   = '0;
`ifdef REG_ARB_LOCK_EN
    bus.lock_amisha = '0;
`endif

    // 1 reset after activity
    do_reset();
    set_d(8'h31, 8'h32, 8'h33, 8'h34);
    bus.req_amisha = 4'b0110;
    tick(); tick(); tick();
    do_reset();
    check("rst_q",    32'(bus.q_amisha),     32'h0);
    check("rst_gnt",  32'(bus.gnt_amisha),   32'h0);
    check("rst_busy", 32'(bus.busy_amisha),  32'h0);
    check("rst_id",   32'(bus.wr_id_amisha), 32'h0);

    // 2 single write
    set_d(8'hA5, 8'h00, 8'h00, 8'h00);
    bus.req_amisha = 4'b0001;
    tick();
    check("single_q",   32'(bus.q_amisha),     32'hA5);
    check("single_gnt", 32'(bus.gnt_amisha),   32'h1);
    check("single_id",  32'(bus.wr_id_amisha), 32'h0);
    bus.req_amisha = 4'b0000;
    tick();
    check("single_gnt_drop", 32'(bus.gnt_amisha), 32'h0);
    tick();
    check("single_idle_q", 32'(bus.q_amisha), 32'hA5);

    // 3 round robin with all requesting
    do_reset();
    set_d(8'h10, 8'h11, 8'h12, 8'h13);
    bus.req_amisha = 4'b1111;
    for (int c = 0; c < 10; c++) tick();
    check("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      check("rr_order", 32'(grants[i]), 32'(i % 4));
      check("rr_q",     32'(gq[i]),     32'(8'h10 + (i % 4)));
    end

    // 4 wrap and skip from pointer 3
    do_reset();
    set_d(8'h40, 8'h41, 8'h42, 8'h43);
    bus.req_amisha = 4'b0100;
    tick();
    bus.req_amisha = 4'b0000;
    tick();
    grants.delete();
    bus.req_amisha = 4'b0101;
    for (int c = 0; c < 6; c++) tick();
    check("wrap_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      check("wrap_first",  32'(grants[0]), 32'd0);
      check("wrap_second", 32'(grants[1]), 32'd2);
      check("wrap_third",  32'(grants[2]), 32'd0);
    end

    // 5 reset during ACK and on a capture edge
    do_reset();
    set_d(8'h50, 8'h77, 8'h52, 8'h53);
    bus.req_amisha = 4'b0010;
    tick();
    reset_amisha = 1'b1;
    bus.req_amisha = 4'b0000;
    tick();
    check("rack_gnt",  32'(bus.gnt_amisha),  32'h0);
    check("rack_q",    32'(bus.q_amisha),    32'h0);
    check("rack_busy", 32'(bus.busy_amisha), 32'h0);
    reset_amisha = 1'b0;
    tick();
    check("rack_nopulse", 32'(bus.gnt_amisha), 32'h0);
    reset_amisha = 1'b1;
    bus.req_amisha = 4'b0010;
    tick();
    check("rcap_gnt", 32'(bus.gnt_amisha), 32'h0);
    check("rcap_q",   32'(bus.q_amisha),   32'h0);
    reset_amisha = 1'b0;
    bus.req_amisha = 4'b1111;
    tick();
    check("rack_next_gnt", 32'(bus.gnt_amisha), 32'h1);
    check("rack_next_q",   32'(bus.q_amisha),   32'h50);
    bus.req_amisha = 4'b0000;
    tick();

`ifdef REG_ARB_LOCK_EN
    // 6 lock keeps requester 1 on top
    do_reset();
    set_d(8'h60, 8'h61, 8'h62, 8'h63);
    bus.req_amisha = 4'b0001;
    tick();
    bus.req_amisha = 4'b0000;
    tick();
    grants.delete();
    bus.req_amisha  = 4'b0011;
    bus.lock_amisha = 4'b0010;
    for (int c = 0; c < 6; c++) tick();
    check("lock_count", 32'(grants.size()), 32'd3);
    foreach (grants[i]) check("lock_id", 32'(grants[i]), 32'd1);
    grants.delete();
    bus.lock_amisha = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    check("unlock_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) check("unlock_zero", 32'(grants[1]), 32'd0);
    bus.req_amisha = 4'b0000;
    tick();
`endif

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset_amisha   = ($urandom_range(0, 39) == 0);
      bus.req_amisha = 4'($urandom);
      bus.d_amisha   = 32'($urandom);
`ifdef REG_ARB_LOCK_EN
      bus.lock_amisha = 4'($urandom);
`endif
      tick();
      checks++;
      assert ($countones(bus.gnt_amisha) <= 1) else begin
        errors++;
        $error("FAIL onehot observed=%0h expected=onehot_or_zero", bus.gnt_amisha);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
